// File: rtl/gates_pkg.sv
// Shared definitions for the two-input gate test interface: gate bit indices,
// checker FSM encoding, expected-pipeline entry and the reference gate function.
package gates_pkg;

   localparam int unsigned NUM_GATES = 7;

   localparam int unsigned GATE_AND  = 0;
   localparam int unsigned GATE_OR   = 1;
   localparam int unsigned GATE_NAND = 2;
   localparam int unsigned GATE_NOR  = 3;
   localparam int unsigned GATE_XOR  = 4;
   localparam int unsigned GATE_XNOR = 5;
   localparam int unsigned GATE_NOT  = 6;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   typedef struct packed {
      logic                 valid;
      logic [1:0]           ab;
      logic [NUM_GATES-1:0] exp;
   } pipe_entry_t;

   function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
      logic [NUM_GATES-1:0] g;
      g            = '0;
      g[GATE_AND]  = a & b;
      g[GATE_OR]   = a | b;
      g[GATE_NAND] = ~(a & b);
      g[GATE_NOR]  = ~(a | b);
      g[GATE_XOR]  = a ^ b;
      g[GATE_XNOR] = ~(a ^ b);
      g[GATE_NOT]  = ~a;
      return g;
   endfunction

endpackage

// File: rtl/gates_exp_pipe.sv
// Delay line aligning expected gate values with the DUT response; LAT=0 is a
// combinational pass-through.
module gates_exp_pipe
   import gates_pkg::*;
#(
   parameter int unsigned LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  pipe_entry_t in_entry,
   output pipe_entry_t out_entry,
   output logic        empty
);

   generate
      if (LAT == 0) begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = clk | rst | flush;
         assign out_entry   = in_entry;
         assign empty       = 1'b1;
      end else begin : g_shift
         pipe_entry_t stage [LAT];

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               for (int unsigned i = 0; i < LAT; i++) stage[i] <= '0;
            end else begin
               stage[0] <= in_entry;
               for (int unsigned i = 1; i < LAT; i++) stage[i] <= stage[i-1];
            end
         end

         // Empty means nothing is still waiting to be compared, including the output stage.
         always_comb begin
            empty = 1'b1;
            for (int unsigned i = 0; i < LAT; i++) begin
               if (stage[i].valid) empty = 1'b0;
            end
         end

         assign out_entry = stage[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/gates_checker.sv
// Response monitor for the two-input gate block: compares c against the expected
// gate values and accumulates per-run vector, error and coverage statistics.
module gates_checker
   import gates_pkg::*;
#(
   parameter int unsigned NUM_VECTORS      = 6,
   parameter int unsigned CNT_W            = 8,
   parameter int unsigned LAT              = 0,
   parameter int unsigned REQUIRE_FULL_COV = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic                 a,
   input  logic                 b,
   input  logic [NUM_GATES-1:0] c,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 mismatch,
   output logic [NUM_GATES-1:0] mismatch_mask,
   output logic [CNT_W-1:0]     vec_count,
   output logic [CNT_W-1:0]     err_count,
   output logic [CNT_W-1:0]     first_fail_idx,
   output logic [1:0]           first_fail_ab,
   output logic [3:0]           coverage
);

   localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t               state;
   logic [CNT_W-1:0]     acc_count;
   logic                 accept;
   logic                 start_ok;
   logic                 cov_ok;
   logic                 pipe_empty;
   pipe_entry_t          issue;
   pipe_entry_t          emerge;
   logic [NUM_GATES-1:0] diff;

   assign accept   = (state == ST_RUN) && in_valid;
   assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign issue    = {accept, a, b, expected_gates(a, b)};
   assign diff     = emerge.exp ^ c;
   assign cov_ok   = (REQUIRE_FULL_COV == 0) || (coverage == 4'hF);
   assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
   assign done     = (state == ST_DONE);

   gates_exp_pipe #(
      .LAT (LAT)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .flush     (start_ok),
      .in_entry  (issue),
      .out_entry (emerge),
      .empty     (pipe_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         acc_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_RUN;
                  acc_count <= '0;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  acc_count <= acc_count + 1'b1;
                  if (acc_count == LAST_VEC - 1'b1) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pipe_empty) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         pass           <= 1'b0;
         mismatch       <= 1'b0;
         mismatch_mask  <= '0;
         vec_count      <= '0;
         err_count      <= '0;
         first_fail_idx <= '0;
         first_fail_ab  <= '0;
         coverage       <= '0;
      end else begin
         mismatch <= 1'b0;
         if (emerge.valid) begin
            if (vec_count != LAST_VEC) vec_count <= vec_count + 1'b1;
            coverage[emerge.ab] <= 1'b1;
            if (diff != '0) begin
               mismatch      <= 1'b1;
               mismatch_mask <= diff;
               // err_count never returns to zero within a run, so zero marks the first failure.
               if (err_count == '0) begin
                  first_fail_idx <= vec_count;
                  first_fail_ab  <= emerge.ab;
               end
               if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
            end
         end
         if ((state == ST_DRAIN) && pipe_empty) pass <= (err_count == '0) && cov_ok;
      end
   end

endmodule

// File: tb/tb_gates_checker.sv
// Bench for gates_checker: three configurations driven with directed and random
// vectors, checked every cycle against a cycle-indexed behavioural model.
module tb_gates_checker;

   localparam int P_NV   [3] = '{6, 3, 6};
   localparam int P_LAT  [3] = '{0, 3, 3};
   localparam int P_MAX  [3] = '{255, 3, 255};
   localparam int P_RFC  [3] = '{1, 0, 1};

   logic clk = 1'b0;
   logic rst;
   logic st [3], iv [3], va [3], vb [3];
   logic [6:0] cc [3], flip [3];
   int mode [3];
   logic [1:0] dly [3][8];
   logic dn [3];

   logic busy0, done0, pass0, mis0, busy1, done1, pass1, mis1, busy2, done2, pass2, mis2;
   logic [6:0] mask0, mask1, mask2;
   logic [7:0] vec0, err0, ffi0, vec2, err2, ffi2;
   logic [1:0] vec1, err1, ffi1;
   logic [1:0] ffab0, ffab1, ffab2;
   logic [3:0] cov0, cov1, cov2;

   int total = 0;
   int bad   = 0;

   // model state, indexed by instance
   bit         m_busy [3], m_done [3], m_pass [3], m_mis [3];
   logic [6:0] m_mask [3];
   int         m_vec [3], m_err [3], m_ffi [3], m_acc [3], m_end [3];
   logic [1:0] m_ffab [3];
   logic [3:0] m_cov [3];
   bit         m_acch [3][16];
   logic [1:0] m_abh [3][16];
   int         nxt = 16;
   bit         armed = 1'b0;

   always #5 clk = ~clk;

   gates_checker #(.NUM_VECTORS(6), .CNT_W(8), .LAT(0), .REQUIRE_FULL_COV(1)) dut0 (
      .clk(clk), .rst(rst), .start(st[0]), .in_valid(iv[0]), .a(va[0]), .b(vb[0]), .c(cc[0]),
      .busy(busy0), .done(done0), .pass(pass0), .mismatch(mis0), .mismatch_mask(mask0),
      .vec_count(vec0), .err_count(err0), .first_fail_idx(ffi0), .first_fail_ab(ffab0),
      .coverage(cov0));

   gates_checker #(.NUM_VECTORS(3), .CNT_W(2), .LAT(3), .REQUIRE_FULL_COV(0)) dut1 (
      .clk(clk), .rst(rst), .start(st[1]), .in_valid(iv[1]), .a(va[1]), .b(vb[1]), .c(cc[1]),
      .busy(busy1), .done(done1), .pass(pass1), .mismatch(mis1), .mismatch_mask(mask1),
      .vec_count(vec1), .err_count(err1), .first_fail_idx(ffi1), .first_fail_ab(ffab1),
      .coverage(cov1));

   gates_checker #(.NUM_VECTORS(6), .CNT_W(8), .LAT(3), .REQUIRE_FULL_COV(1)) dut2 (
      .clk(clk), .rst(rst), .start(st[2]), .in_valid(iv[2]), .a(va[2]), .b(vb[2]), .c(cc[2]),
      .busy(busy2), .done(done2), .pass(pass2), .mismatch(mis2), .mismatch_mask(mask2),
      .vec_count(vec2), .err_count(err2), .first_fail_idx(ffi2), .first_fail_ab(ffab2),
      .coverage(cov2));

   always_comb begin
      dn[0] = done0;
      dn[1] = done1;
      dn[2] = done2;
   end

   function automatic logic [6:0] gold(input logic [1:0] ab);
      logic x, y;
      x = ab[1];
      y = ab[0];
      return {~x, ~(x ^ y), x ^ y, ~(x | y), ~(x & y), x | y, x & y};
   endfunction

   // Emulated gate DUT: responds LAT cycles after the vector, with optional faults.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         dly[k][0] <= {va[k], vb[k]};
         for (int i = 1; i < 8; i++) dly[k][i] <= dly[k][i-1];
      end
   end

   always_comb begin
      logic [1:0] src;
      logic [6:0] g;
      for (int k = 0; k < 3; k++) begin
         src = {va[k], vb[k]};
         if (P_LAT[k] != 0) src = dly[k][P_LAT[k]-1];
         g = gold(src);
         case (mode[k])
            1:       cc[k] = g & 7'h6F;
            2:       cc[k] = 7'h00;
            3:       cc[k] = g ^ flip[k];
            default: cc[k] = g;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_inst(input int k, input logic bu, input logic dne, input logic ps,
                           input logic mi, input logic [6:0] mk, input logic [7:0] vc,
                           input logic [7:0] er, input logic [7:0] fi, input logic [1:0] fa,
                           input logic [3:0] cv);
      chk($sformatf("u%0d.busy", k), bu, m_busy[k]);
      chk($sformatf("u%0d.done", k), dne, m_done[k]);
      chk($sformatf("u%0d.pass", k), ps, m_pass[k]);
      chk($sformatf("u%0d.mismatch", k), mi, m_mis[k]);
      chk($sformatf("u%0d.mask", k), mk, m_mask[k]);
      chk($sformatf("u%0d.vec_count", k), vc, m_vec[k]);
      chk($sformatf("u%0d.err_count", k), er, m_err[k]);
      chk($sformatf("u%0d.ff_idx", k), fi, m_ffi[k]);
      chk($sformatf("u%0d.ff_ab", k), fa, m_ffab[k]);
      chk($sformatf("u%0d.coverage", k), cv, m_cov[k]);
   endtask

   task automatic model_clear(input int k);
      m_done[k] = 1'b0; m_pass[k] = 1'b0; m_mask[k] = '0; m_vec[k] = 0; m_err[k] = 0;
      m_ffi[k] = 0; m_ffab[k] = '0; m_cov[k] = '0; m_acc[k] = 0; m_end[k] = 0;
      for (int i = 0; i < 16; i++) m_acch[k][i] = 1'b0;
   endtask

   // Predicts the effect of the upcoming rising edge (index nxt) from the current inputs.
   task automatic model_step(input int k);
      int slot, e;
      logic [1:0] ab;
      logic [6:0] d;
      slot = nxt % 16;
      m_mis[k] = 1'b0;
      if (rst) begin
         model_clear(k);
         m_busy[k] = 1'b0;
         return;
      end
      if (st[k] && !m_busy[k]) begin
         model_clear(k);
         m_busy[k] = 1'b1;
         return;
      end
      m_acch[k][slot] = m_busy[k] && (m_acc[k] < P_NV[k]) && iv[k];
      m_abh[k][slot]  = {va[k], vb[k]};
      if (m_acch[k][slot]) begin
         m_acc[k]++;
         if (m_acc[k] == P_NV[k]) m_end[k] = nxt + P_LAT[k] + 1;
      end
      e = (nxt - P_LAT[k]) % 16;
      if (m_busy[k] && m_acch[k][e]) begin
         ab = m_abh[k][e];
         d  = gold(ab) ^ cc[k];
         if (d != 0) begin
            if (m_err[k] == 0) begin
               m_ffi[k]  = m_vec[k];
               m_ffab[k] = ab;
            end
            if (m_err[k] < P_MAX[k]) m_err[k]++;
            m_mask[k] = d;
            m_mis[k]  = 1'b1;
         end
         m_vec[k]++;
         m_cov[k][ab] = 1'b1;
      end
      if (m_busy[k] && (m_acc[k] == P_NV[k]) && (nxt == m_end[k])) begin
         m_busy[k] = 1'b0;
         m_done[k] = 1'b1;
         m_pass[k] = (m_err[k] == 0) && ((P_RFC[k] == 0) || (m_cov[k] == 4'hF));
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk_inst(0, busy0, done0, pass0, mis0, mask0, vec0, err0, ffi0, ffab0, cov0);
         chk_inst(1, busy1, done1, pass1, mis1, mask1, {6'b0, vec1}, {6'b0, err1},
                  {6'b0, ffi1}, ffab1, cov1);
         chk_inst(2, busy2, done2, pass2, mis2, mask2, vec2, err2, ffi2, ffab2, cov2);
      end
      for (int k = 0; k < 3; k++) model_step(k);
      if (rst) armed = 1'b1;
      nxt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_run(input int k, input logic with_vec);
      st[k] = 1'b1; iv[k] = with_vec; va[k] = 1'b1; vb[k] = 1'b1;
      tick();
      st[k] = 1'b0; iv[k] = 1'b0;
   endtask

   task automatic send(input int k, input logic [1:0] ab);
      iv[k] = 1'b1; va[k] = ab[1]; vb[k] = ab[0];
      tick();
      iv[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int budget);
      int n;
      n = 0;
      while (!dn[k] && n < budget) begin
         tick();
         n++;
      end
      chk($sformatf("u%0d.done_wait", k), dn[k], 1'b1);
   endtask

   logic [1:0] vset_a [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
   logic [1:0] vset_b [6] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
   logic [1:0] vset_c [3] = '{2'b00, 2'b01, 2'b10};

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         st[k] = 1'b0; iv[k] = 1'b0; va[k] = 1'b0; vb[k] = 1'b0; flip[k] = '0; mode[k] = 0;
      end
      repeat (3) tick();
      rst = 1'b0;
      chk("rst.busy", busy0, 1'b0);
      chk("rst.done", done0, 1'b0);
      chk("rst.vec", vec0, 8'd0);

      // golden run; vector alongside start and one offered during drain are ignored
      begin_run(0, 1'b1);
      foreach (vset_a[i]) send(0, vset_a[i]);
      chk("t1.done_early", done0, 1'b0);
      send(0, 2'b11);
      chk("t1.done_lat", done0, 1'b1);
      chk("t1.vec", vec0, 8'd6);
      chk("t1.err", err0, 8'd0);
      chk("t1.cov", cov0, 4'hF);
      chk("t1.pass", pass0, 1'b1);

      mode[0] = 1;
      begin_run(0, 1'b0);
      foreach (vset_a[i]) send(0, vset_a[i]);
      wait_done(0, 10);
      chk("t2.err", err0, 8'd3);
      chk("t2.ff_idx", ffi0, 8'd0);
      chk("t2.ff_ab", ffab0, 2'b01);
      chk("t2.mask", mask0, 7'b0010000);
      chk("t2.pass", pass0, 1'b0);

      mode[0] = 0;
      begin_run(0, 1'b0);
      foreach (vset_b[i]) send(0, vset_b[i]);
      wait_done(0, 10);
      chk("t3.cov", cov0, 4'b1110);
      chk("t3.err", err0, 8'd0);
      chk("t3.pass", pass0, 1'b0);

      begin_run(0, 1'b0);
      for (int i = 0; i < 3; i++) send(0, vset_a[i]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4.busy", busy0, 1'b0);
      chk("t4.done", done0, 1'b0);
      chk("t4.vec", vec0, 8'd0);
      chk("t4.cov", cov0, 4'h0);
      begin_run(0, 1'b0);
      foreach (vset_a[i]) send(0, vset_a[i]);
      wait_done(0, 10);
      chk("t4.pass", pass0, 1'b1);
      chk("t4.vec2", vec0, 8'd6);

      begin_run(2, 1'b0);
      foreach (vset_a[i]) send(2, vset_a[i]);
      repeat (3) tick();
      chk("t5.done_early", done2, 1'b0);
      tick();
      chk("t5.done_lat", done2, 1'b1);
      chk("t5.pass", pass2, 1'b1);

      mode[1] = 2;
      for (int rep = 0; rep < 2; rep++) begin
         begin_run(1, 1'b0);
         chk("t6.vec_clr", vec1, 2'd0);
         chk("t6.err_clr", err1, 2'd0);
         foreach (vset_c[i]) send(1, vset_c[i]);
         wait_done(1, 12);
         chk("t6.err", err1, 2'd3);
         chk("t6.vec", vec1, 2'd3);
         chk("t6.ff_ab", ffab1, 2'b00);
         chk("t6.mask", mask1, 7'h16);
         chk("t6.pass", pass1, 1'b0);
      end

      for (int r = 0; r < 60; r++) begin
         int k;
         k = int'($urandom_range(0, 2));
         mode[k] = ($urandom_range(0, 1) != 0) ? 3 : 0;
         begin_run(k, 1'($urandom));
         for (int cyc = 0; cyc < 30; cyc++) begin
            iv[k]   = ($urandom_range(0, 3) != 0);
            va[k]   = 1'($urandom);
            vb[k]   = 1'($urandom);
            flip[k] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            st[k]   = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
         end
         st[k] = 1'b0; iv[k] = 1'b0; flip[k] = '0; rst = 1'b0;
         tick();
      end

      repeat (4) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

endmodule

// File: doc/gates_checker.md
Name: gates_checker

Overview:
- Self-checking response monitor for the two-input logic-gate block. It is the observing end of the gate test interface, opposite the stimulus driver.
- Accepts each applied (a, b) vector and the seven gate outputs, either in the same cycle or LAT cycles later. Computes the expected values and compares them.
- Accumulates vector, error and input-coverage statistics over a run of NUM_VECTORS vectors, then reports pass/fail.
- Sits beside the gate DUT in benches and FPGA self-test wrappers.

Parameters:
- NUM_VECTORS, 6: vectors per run (1..2^CNT_W-1).
- CNT_W, 8: width of the vector and error counters.
- LAT, 0: cycles from an accepted in_valid until the DUT outputs on c are valid (0..7).
- REQUIRE_FULL_COV, 1: if 1, pass also requires all four (a,b) combinations to have been seen.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  a/b carry a vector this cycle.
- a  in  1  applied input a.
- b  in  1  applied input b.
- c  in  7  DUT outputs. c[0]=AND, c[1]=OR, c[2]=NAND, c[3]=NOR, c[4]=XOR, c[5]=XNOR, c[6]=NOT a.
- busy  out  1  run in progress.
- done  out  1  run finished; results stable.
- pass  out  1  valid only while done is high.
- mismatch  out  1  one-cycle pulse, one cycle after a failing compare.
- mismatch_mask  out  7  bits of c that differed in the last failing compare.
- vec_count  out  CNT_W  vectors compared so far.
- err_count  out  CNT_W  failing vectors; saturates at all-ones.
- first_fail_idx  out  CNT_W  vec_count value of the first failing vector.
- first_fail_ab  out  2  {a,b} of the first failing vector.
- coverage  out  4  bit {a,b} is set once that combination has been compared.

Behaviour:
- Interface: the clock port is clk and the reset port is rst. One clock domain. Reset is synchronous and active-high.
- Reset: FSM goes to IDLE. Every output is 0. The expected pipeline is flushed. A reset mid-run abandons the run without producing done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. All counters, coverage, mismatch_mask, first_fail_* and the pipeline are cleared in that same edge.
  - RUN: in_valid is accepted. When the NUM_VECTORS-th vector is accepted, go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the final compare is registered, then go to DONE. With LAT=0 this takes exactly 1 cycle.
  - DONE -> RUN on start, clearing as from IDLE. Otherwise hold every result.
- busy = 1 in RUN and DRAIN. done = 1 only in DONE.
- in_valid outside RUN is ignored; this includes DRAIN. start outside IDLE/DONE is ignored.
- Expected values: AND=a&b, OR=a|b, NAND=~(a&b), NOR=~(a|b), XOR=a^b, XNOR=~(a^b), NOT=~a.
- Latency:
  - The expected vector plus its {a,b} and a valid bit travel through an LAT-deep shift register.
  - The compare happens when the valid bit emerges, against c in that cycle. With LAT=0 this is the in_valid cycle.
  - Compare results are registered, so mismatch, vec_count, err_count and coverage update 1 cycle after the compare.
- Failing compare, defined as (expected ^ c) != 0:
  - mismatch pulses, mismatch_mask loads the diff, and err_count increments unless saturated.
  - On the first failure of the run, first_fail_idx takes the pre-increment vec_count and first_fail_ab takes {a,b}.
  - mismatch_mask holds its value until the next failure or a new run.
- Back-to-back in_valid every cycle is supported at full rate. There are no stalls.
- pass = (err_count == 0) && (!REQUIRE_FULL_COV || coverage == 4'hF). It is registered on entry to DONE.
- vec_count never exceeds NUM_VECTORS.
- If start and in_valid arrive in the same IDLE cycle, the vector is ignored. Acceptance begins the following cycle.

Decomposition:
- Shared package gates_pkg holds:
  - gate index constants (GATE_AND=0 .. GATE_NOT=6) and NUM_GATES=7;
  - FSM state typedef/encoding;
  - function expected_gates(a,b) returning 7 bits, also usable by benches.
- One sub-module, gates_exp_pipe: the LAT-deep shift register carrying {valid, a, b, expected[6:0]}, with a pass-through when LAT=0.

Test Plan:
- Golden DUT, LAT=0, NUM_VECTORS=6, vectors 01,10,11,00,10,11 -> done after the 7th cycle from the first vector. vec_count=6, err_count=0, coverage=4'hF, pass=1, mismatch never pulses.
- Same run with c[4] forced to 0 -> failures on vectors 01,10,10. err_count=3, first_fail_idx=0, first_fail_ab=2'b01, mismatch_mask=7'b0010000, pass=0.
- LAT=3, golden DUT delayed 3 cycles, 6 back-to-back vectors -> no mismatch. done 4 cycles after the last accept. pass=1.
- REQUIRE_FULL_COV=1, vectors 01,10,11,01,10,11 on a golden DUT -> coverage=4'b1110, err_count=0, pass=0.
- rst asserted for one cycle mid-run after 3 vectors -> all outputs 0 and IDLE next cycle, no done. A new start with 6 golden vectors -> pass=1, vec_count=6.
- CNT_W=2, NUM_VECTORS=3, DUT with c=7'h00 -> err_count=3 with no wrap. start again from DONE -> counters clear to 0 and the run repeats with identical results.
